// File: rtl/mem_responder.sv
// Purpose: single-ported word RAM that serves the multicycle core's unified bus, one request at a time.
// Latency: ack is high LATENCY+1 cycles after the accept edge. At most one transaction every LATENCY+2 cycles.
// Backpressure: stall = req & ~ack holds the core. req is sampled only while idle.
//
// Ports:
//   clk, reset (sync, active-low)         clock and reset
//   req, we, addr, wdata, be              request from the core, latched on accept
//   rdata, ack, err                       registered response (err qualified by ack)
//   stall                                 combinational hold to the core
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        stall
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT4 = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    // The request being completed. With LATENCY=0 the RESP-entry edge is the
    // accept edge itself, so the live bus inputs must be used; otherwise the
    // values latched at accept are used.
    logic             cur_we;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic [3:0]       cur_be;
    logic             cur_bad;
    logic [IDX_W-1:0] cur_idx;
    logic [31:0]      rd_word;
    logic             enter_resp;
    logic             mem_wr;

    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = we;
            cur_addr  = addr;
            cur_wdata = wdata;
            cur_be    = be;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_be    = be_q;
        end
    end

    // Misaligned, or any word-index bit beyond the RAM, is an error. The whole
    // 30-bit word index is compared so stray high address bits cannot alias.
    assign cur_bad = (cur_addr[1:0] != 2'b00) ||
                     ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign cur_idx = cur_addr[IDX_W+1:2];
    assign rd_word = mem[cur_idx];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rdata_d    = rdata_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        enter_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    be_d    = be;
                    cnt_d   = LAT4;
                    if (LAT4 == 4'd0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // <= rather than == so a corrupted zero count cannot strand the FSM
                if (cnt_q <= 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Commit and read capture both happen on the edge that enters RESP.
        if (enter_resp) begin
            ack_d = 1'b1;
            err_d = cur_bad;
            if (cur_bad) begin
                rdata_d = 32'd0;
            end else if (!cur_we) begin
                rdata_d = rd_word;
            end
        end
    end

    // Reset gates the write so a transaction cut short by reset never lands.
    assign mem_wr = reset & enter_resp & cur_we & ~cur_bad;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) begin
                    mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign stall = req & ~ack_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY=2 and LATENCY=0) checked every
// cycle against a transaction-level model, plus directed literal expectations.
module tb_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT0  = 2;
    localparam int LAT1  = 0;

    logic        clk = 1'b0;
    logic        reset_s;
    logic        req_s   [2];
    logic        we_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [3:0]  be_s    [2];
    logic [31:0] rdata_s [2];
    logic        ack_s   [2];
    logic        err_s   [2];
    logic        stall_s [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) u_l2 (
        .clk(clk), .reset(reset_s), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .be(be_s[0]), .rdata(rdata_s[0]), .ack(ack_s[0]),
        .err(err_s[0]), .stall(stall_s[0])
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) u_l0 (
        .clk(clk), .reset(reset_s), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .be(be_s[1]), .rdata(rdata_s[1]), .ack(ack_s[1]),
        .err(err_s[1]), .stall(stall_s[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    // ---------------- transaction-level model ----------------
    // A request seen while the responder is free completes LATENCY edges later;
    // the responder is free again two edges after that. Reset cancels anything pending.
    int          cyc = 0;
    int          idle_from [2] = '{0, 0};
    bit          p_vld   [2];
    bit          p_we    [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    logic [3:0]  p_be    [2];
    int          p_due   [2];
    bit          exp_ack [2];
    bit          exp_err [2];
    logic [31:0] exp_rdata [2];
    bit          rd_known  [2];
    logic [31:0] mmem   [2][DEPTH];
    bit          mknown [2][DEPTH];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            exp_ack[k] = 1'b0;
            if (!reset_s) begin
                p_vld[k]     = 1'b0;
                idle_from[k] = cyc + 1;
                exp_rdata[k] = 32'd0;
                rd_known[k]  = 1'b1;
                exp_err[k]   = 1'b0;
            end else begin
                if (cyc >= idle_from[k] && req_s[k]) begin
                    p_vld[k]     = 1'b1;
                    p_we[k]      = we_s[k];
                    p_addr[k]    = addr_s[k];
                    p_wdata[k]   = wdata_s[k];
                    p_be[k]      = be_s[k];
                    p_due[k]     = cyc + lat_of(k);
                    idle_from[k] = cyc + lat_of(k) + 2;
                end
                if (p_vld[k] && p_due[k] == cyc) begin
                    logic [31:0] a;
                    int idx;
                    a = p_addr[k];
                    exp_ack[k] = 1'b1;
                    p_vld[k]   = 1'b0;
                    if (a[1:0] != 2'b00 || a[31:2] >= DEPTH) begin
                        exp_err[k]   = 1'b1;
                        exp_rdata[k] = 32'd0;
                        rd_known[k]  = 1'b1;
                    end else begin
                        exp_err[k] = 1'b0;
                        idx = int'(a[31:2]);
                        if (p_we[k]) begin
                            for (int b = 0; b < 4; b++)
                                if (p_be[k][b]) mmem[k][idx][8*b +: 8] = p_wdata[k][8*b +: 8];
                            mknown[k][idx] = mknown[k][idx] | (p_be[k] == 4'hF);
                        end else begin
                            exp_rdata[k] = mmem[k][idx];
                            rd_known[k]  = mknown[k][idx];
                        end
                    end
                end
            end
        end
        cyc++;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("ack[%0d] cyc%0d", k, cyc), {31'd0, ack_s[k]}, {31'd0, exp_ack[k]});
                check($sformatf("stall[%0d] cyc%0d", k, cyc), {31'd0, stall_s[k]},
                      {31'd0, req_s[k] & ~exp_ack[k]});
                if (exp_ack[k])
                    check($sformatf("err[%0d] cyc%0d", k, cyc), {31'd0, err_s[k]}, {31'd0, exp_err[k]});
                if (rd_known[k])
                    check($sformatf("rdata[%0d] cyc%0d", k, cyc), rdata_s[k], exp_rdata[k]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Entered and left just after a rising edge. lat counts edges from accept to
    // the edge that ends the ack cycle.
    task automatic access(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, output logic [31:0] rd, output logic er,
                          output int lat);
        bit got;
        req_s[k] = 1'b1; we_s[k] = w; addr_s[k] = a; wdata_s[k] = d; be_s[k] = b;
        @(posedge clk); #1;
        req_s[k] = 1'b0;
        got = 1'b0; lat = 1; rd = '0; er = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ack_s[k]) begin
                got = 1'b1; rd = rdata_s[k]; er = err_s[k];
            end else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout[%0d]: no ack for addr %h, required within 40 cycles", k, a);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required to end by 2ms");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        reset_s = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_s[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = '0; wdata_s[k] = '0; be_s[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_ack", {31'd0, ack_s[0]}, 32'd0);
        check("rst_err", {31'd0, err_s[0]}, 32'd0);
        check("rst_rdata", rdata_s[0], 32'd0);
        @(posedge clk); #1;
        reset_s = 1'b1;

        // Write then read, LATENCY=2.
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        check("wr10_err", {31'd0, er}, 32'd0);
        check("wr10_lat", lat, 3);
        access(0, 1'b1, 32'h0, 32'h01020304, 4'hF, rd, er, lat);
        access(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        check("rd10_data", rd, 32'hDEADBEEF);
        check("rd10_err", {31'd0, er}, 32'd0);

        // Byte enable: only lane 0 changes.
        access(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lat);
        check("wrb_rdata_hold", rd, 32'hDEADBEEF);
        access(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        check("rd_be_data", rd, 32'hDEADBEAA);

        // Errors: misaligned read, out-of-range write, high-bit read.
        access(0, 1'b0, 32'h12, 32'h0, 4'hF, rd, er, lat);
        check("mis_err", {31'd0, er}, 32'd1);
        check("mis_rdata", rd, 32'd0);
        access(0, 1'b1, 32'(4 * DEPTH), 32'hFFFFFFFF, 4'hF, rd, er, lat);
        check("oor_err", {31'd0, er}, 32'd1);
        access(0, 1'b0, 32'h8000_0000, 32'h0, 4'hF, rd, er, lat);
        check("hi_err", {31'd0, er}, 32'd1);
        access(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat);
        check("word0_kept", rd, 32'h01020304);

        // Reset held for two cycles with a write request pending.
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h10; wdata_s[0] = 32'h11111111; be_s[0] = 4'hF;
        reset_s = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rstreq_ack", {31'd0, ack_s[0]}, 32'd0);
            check("rstreq_err", {31'd0, err_s[0]}, 32'd0);
            check("rstreq_rdata", rdata_s[0], 32'd0);
            check("rstreq_stall", {31'd0, stall_s[0]}, 32'd1);
        end
        @(posedge clk); #1;
        reset_s = 1'b1; req_s[0] = 1'b0;
        access(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        check("rstreq_nowrite", rd, 32'hDEADBEAA);

        // Reset during WAIT discards the write.
        access(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, er, lat);
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h20; wdata_s[0] = 32'h12345678; be_s[0] = 4'hF;
        @(posedge clk); #1;
        req_s[0] = 1'b0;
        reset_s  = 1'b0;
        @(posedge clk); #1;
        reset_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_noack", {31'd0, ack_s[0]}, 32'd0);
        end
        @(posedge clk); #1;
        access(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
        check("midrst_old", rd, 32'hCAFEF00D);

        // LATENCY=0: single access latency, then back-to-back with req held high.
        access(1, 1'b1, 32'h44, 32'h0BADF00D, 4'hF, rd, er, lat);
        check("l0_lat", lat, 1);
        req_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 32'h40; wdata_s[1] = 32'hA5A5A5A5; be_s[1] = 4'hF;
        @(negedge clk);
        check("b2b_c0_ack", {31'd0, ack_s[1]}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_c1_ack", {31'd0, ack_s[1]}, 32'd1);
        check("b2b_c1_stall", {31'd0, stall_s[1]}, 32'd0);
        @(posedge clk); #1;
        we_s[1] = 1'b0;
        @(negedge clk);
        check("b2b_c2_ack", {31'd0, ack_s[1]}, 32'd0);
        check("b2b_c2_stall", {31'd0, stall_s[1]}, 32'd1);
        @(posedge clk); #1;
        req_s[1] = 1'b0;
        @(negedge clk);
        check("b2b_c3_ack", {31'd0, ack_s[1]}, 32'd1);
        check("b2b_c3_rdata", rdata_s[1], 32'hA5A5A5A5);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_c4_ack", {31'd0, ack_s[1]}, 32'd0);
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
